// File: rtl/svv_pkg.sv
// Shared definitions for the status value vector and its push arbiter.
package svv_pkg;

  // Default geometry, shared with status_value_vector.
  localparam int unsigned DEF_DEPTH = 8;
  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_NREQ  = 4;

  // Output stage occupancy of the push arbiter.
  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_LOADED = 1'b1
  } stage_state_e;

  // Ceiling log2, never less than 1 so index ports always have a bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/svv_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr wins.
module svv_rr_arbiter
  import svv_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]        req,
  input  logic [clog2(NREQ)-1:0] ptr,
  input  logic                   en,
  output logic [NREQ-1:0]        gnt,
  output logic [clog2(NREQ)-1:0] idx
);

  localparam int unsigned IW = clog2(NREQ);

  int unsigned   pos;
  logic [IW-1:0] pos_idx;
  logic          found;

  // Scan NREQ slots starting at ptr with wrap; grant the first requester seen.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    found   = 1'b0;
    pos     = '0;
    pos_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      pos = 32'(ptr) + i;
      if (pos >= NREQ) pos = pos - NREQ;
      pos_idx = IW'(pos);
      if (en && !found && req[pos_idx]) begin
        gnt[pos_idx] = 1'b1;
        idx          = pos_idx;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/svv_push_arbiter.sv
// Round-robin push arbiter feeding the single push port of a status value
// vector through a registered output stage that holds under full_i.
module svv_push_arbiter
  import svv_pkg::*;
#(
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rsn_i,
  input  logic [NREQ-1:0]        req_i,
  input  logic [NREQ*WIDTH-1:0]  value_i,
  output logic [NREQ-1:0]        gnt_o,
  output logic                   push_o,
  output logic [WIDTH-1:0]       value_o,
  output logic [clog2(NREQ)-1:0] src_o,
  input  logic                   full_i,
  output logic                   busy_o,
  output logic [CNT_W-1:0]       cnt_o
);

  localparam int unsigned IW = clog2(NREQ);

  stage_state_e     state_q;
  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;
  logic [IW-1:0]    src_q;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    ptr_d;
  logic [CNT_W-1:0] cnt_q;

  logic             accept;
  logic             ld;
  logic             arb_en;
  logic             granted;
  logic [NREQ-1:0]  gnt;
  logic [IW-1:0]    win;
  logic [WIDTH-1:0] vals [NREQ];

  // Unpack the flat value bus so the winner can be selected by index.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign vals[g] = value_i[g*WIDTH +: WIDTH];
  end

  // The stage reloads when empty or when its entry leaves this cycle.
  assign accept = (state_q == ST_LOADED) && !full_i;
  assign ld     = (state_q == ST_EMPTY) || accept;
  // Reset suppresses grants so no requester believes it was served.
  assign arb_en = ld && rsn_i;

  svv_rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .req (req_i),
    .ptr (ptr_q),
    .en  (arb_en),
    .gnt (gnt),
    .idx (win)
  );

  assign granted = |gnt;
  assign value_d = vals[win];
  assign ptr_d   = (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);

  // Output stage, rotating pointer and accept counter.
  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      state_q <= ST_EMPTY;
      value_q <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (accept) cnt_q <= cnt_q + CNT_W'(1);
      if (ld) begin
        if (granted) begin
          state_q <= ST_LOADED;
          value_q <= value_d;
          src_q   <= win;
          ptr_q   <= ptr_d;
        end else begin
          state_q <= ST_EMPTY;
        end
      end
    end
  end

  assign gnt_o   = gnt;
  assign push_o  = (state_q == ST_LOADED);
  assign busy_o  = push_o;
  assign value_o = value_q;
  assign src_o   = src_q;
  assign cnt_o   = cnt_q;

endmodule

// File: tb/tb_svv_push_arbiter.sv
// Scoreboard bench for svv_push_arbiter: a transaction-level model predicts
// grants and queues expected pushes; a negedge monitor checks each push.
module tb_svv_push_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned W     = 4;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned IW    = 2;

  logic                clk = 1'b0;
  logic                rsn_i;
  logic [NREQ-1:0]     req_i;
  logic [NREQ*W-1:0]   value_i;
  logic [NREQ-1:0]     gnt_o;
  logic                push_o;
  logic [W-1:0]        value_o;
  logic [IW-1:0]       src_o;
  logic                full_i;
  logic                busy_o;
  logic [CNT_W-1:0]    cnt_o;

  always #5 clk = ~clk;

  svv_push_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (W),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i   (clk),
    .rsn_i   (rsn_i),
    .req_i   (req_i),
    .value_i (value_i),
    .gnt_o   (gnt_o),
    .push_o  (push_o),
    .value_o (value_o),
    .src_o   (src_o),
    .full_i  (full_i),
    .busy_o  (busy_o),
    .cnt_o   (cnt_o)
  );

  typedef struct {
    logic [W-1:0] v;
    int unsigned  s;
  } ent_t;

  int tests = 0;
  int fails = 0;

  // Reference model: whether an entry is waiting, rotation start, accept count.
  bit               m_loaded;
  int unsigned      m_ptr;
  logic [CNT_W-1:0] m_cnt;
  ent_t             sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs after the edge, compare against the model, then
  // advance the model to what the coming edge should produce.
  task automatic step(input logic r, input logic [NREQ-1:0] rq,
                      input logic [NREQ*W-1:0] v, input logic f, output int gw);
    bit acc;
    bit ld;
    int unsigned k;
    logic [NREQ-1:0] exp_gnt;
    @(posedge clk);
    #1;
    rsn_i = r; req_i = rq; value_i = v; full_i = f;
    #1;
    acc = m_loaded && !f;
    ld  = !m_loaded || acc;
    gw  = -1;
    if (r && ld) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        k = (m_ptr + i) % NREQ;
        if (gw < 0 && rq[k]) gw = int'(k);
      end
    end
    exp_gnt = '0;
    if (gw >= 0) exp_gnt[gw] = 1'b1;
    check("gnt", 32'(gnt_o), 32'(exp_gnt));
    check("push", 32'(push_o), 32'(m_loaded));
    check("busy", 32'(busy_o), 32'(m_loaded));
    check("cnt", 32'(cnt_o), 32'(m_cnt));
    if (!r) begin
      m_loaded = 1'b0;
      m_ptr    = 0;
      m_cnt    = '0;
      sb.delete();
    end else begin
      if (acc) m_cnt = m_cnt + CNT_W'(1);
      if (ld) begin
        if (gw >= 0) begin
          m_loaded = 1'b1;
          m_ptr    = (int'(gw) + 1) % NREQ;
          sb.push_back('{v[gw*W +: W], int'(gw)});
        end else begin
          m_loaded = 1'b0;
        end
      end
    end
  endtask

  // Monitor: every presented push must match the oldest expected entry.
  always @(negedge clk) begin
    if (rsn_i === 1'b1 && push_o === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_push: got value %0h src %0d expected no push", value_o, src_o);
      end else begin
        check("value", 32'(value_o), 32'(sb[0].v));
        check("src", 32'(src_o), sb[0].s);
        if (full_i === 1'b0) void'(sb.pop_front());
      end
    end
  end

  localparam logic [NREQ-1:0] NONE = '0;
  localparam logic [NREQ*W-1:0] V0 = '0;

  initial begin
    int gw;
    logic [NREQ-1:0]   hreq;
    logic [NREQ*W-1:0] hval;
    logic              r;
    logic              f;
    int                guard;

    rsn_i = 1'b0; req_i = '0; value_i = '0; full_i = 1'b0;
    m_loaded = 1'b0; m_ptr = 0; m_cnt = '0;
    repeat (2) @(posedge clk);

    // Single requester 2 with value 5.
    step(1'b1, 4'b0100, 16'h0500, 1'b0, gw);
    step(1'b1, NONE, V0, 1'b0, gw);
    step(1'b1, NONE, V0, 1'b0, gw);
    step(1'b1, NONE, V0, 1'b0, gw);

    // All four requesting: order 0,1,2,3,0 back-to-back.
    step(1'b0, NONE, V0, 1'b0, gw);
    repeat (5) step(1'b1, 4'b1111, 16'h4321, 1'b0, gw);
    repeat (2) step(1'b1, NONE, V0, 1'b0, gw);

    // Stall under full, then accept plus next grant in one cycle.
    step(1'b0, NONE, V0, 1'b0, gw);
    step(1'b1, 4'b0001, 16'h0009, 1'b0, gw);
    repeat (3) step(1'b1, 4'b0010, 16'h00A0, 1'b1, gw);
    step(1'b1, 4'b0010, 16'h00A0, 1'b0, gw);
    repeat (2) step(1'b1, NONE, V0, 1'b0, gw);

    // Requesters 1 and 3 only, pointer moved to 2 first.
    step(1'b0, NONE, V0, 1'b0, gw);
    step(1'b1, 4'b0010, 16'h00B0, 1'b0, gw);
    repeat (3) step(1'b1, 4'b1010, 16'hC0D0, 1'b0, gw);
    repeat (2) step(1'b1, NONE, V0, 1'b0, gw);

    // Reset while loaded and stalled; priority restarts at requester 0.
    step(1'b1, 4'b0100, 16'h0700, 1'b0, gw);
    step(1'b1, NONE, V0, 1'b1, gw);
    step(1'b0, NONE, V0, 1'b1, gw);
    step(1'b1, 4'b1111, 16'h8765, 1'b0, gw);
    repeat (2) step(1'b1, NONE, V0, 1'b0, gw);

    // Randomized traffic honouring the hold-until-granted rule.
    hreq = '0;
    hval = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!hreq[k]) begin
          hreq[k] = ($urandom_range(0, 99) < 40);
          hval[k*W +: W] = W'($urandom);
        end
      end
      r = ($urandom_range(0, 199) != 0);
      f = ($urandom_range(0, 99) < 30);
      step(r, hreq, hval, f, gw);
      if (!r) hreq = '0;
      else if (gw >= 0) hreq[gw] = 1'b0;
    end

    // Counter wrap: run accepts up to 0xFFFF, then one more.
    step(1'b0, NONE, V0, 1'b0, gw);
    guard = 0;
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      step(1'b1, 4'b0001, 16'h0003, 1'b0, gw);
      guard++;
    end
    if (guard >= 70000) begin
      tests++;
      fails++;
      $display("FAIL cnt_preload: got %0h expected ffff within budget", cnt_o);
    end
    step(1'b1, 4'b0001, 16'h0003, 1'b0, gw);
    step(1'b1, NONE, V0, 1'b0, gw);
    check("cnt_wrap", 32'(cnt_o), 32'd0);
    repeat (2) step(1'b1, NONE, V0, 1'b0, gw);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
